cca_energy_detect: RTL and testbench

Clear-channel-assessment energy detector that consumes the calibrated `rssi_half_db` / `rssi_half_db_valid` stream from the RSSI stage. It declares the channel busy or idle with a threshold, hysteresis and consecutive-sample debounce state machine. It also produces edge strobes for the CSMA/backoff logic and saturating busy/total sample counters for channel-occupancy statistics read over the register interface.

---
 rtl/cca_energy_detect.sv | 106 ++++++++++
 tb/tb_cca_energy_detect.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cca_energy_detect.sv
// cca_energy_detect: CCA busy/idle decision with threshold, hysteresis and debounce,
// plus edge strobes and saturating occupancy counters.
module cca_energy_detect #(
    parameter int RSSI_HALF_DB_WIDTH = 11,
    parameter int HYST_WIDTH         = 5,
    parameter int DEBOUNCE_WIDTH     = 8,
    parameter int STAT_CNT_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                                 rssi_half_db_valid,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
    input  logic        [HYST_WIDTH-1:0]         rssi_hyst,
    input  logic        [DEBOUNCE_WIDTH-1:0]     enter_cnt_th,
    input  logic        [DEBOUNCE_WIDTH-1:0]     exit_cnt_th,
    input  logic                                 force_busy,
    input  logic                                 stat_clear,
    output logic                                 ch_busy,
    output logic                                 ch_busy_rise,
    output logic                                 ch_busy_fall,
    output logic        [STAT_CNT_WIDTH-1:0]     busy_sample_cnt,
    output logic        [STAT_CNT_WIDTH-1:0]     total_sample_cnt
);
    typedef enum logic [1:0] {IDLE, ENTER, BUSY, EXIT} state_t;
    state_t state, state_nx;
    logic [DEBOUNCE_WIDTH-1:0] dcnt, dcnt_nx, dcnt_inc, enter_eff, exit_eff;
    logic signed [RSSI_HALF_DB_WIDTH+1:0] rssi_x, idle_th;
    logic above, below, busy_nx;

    // two guard bits keep rssi_th - rssi_hyst from wrapping at the negative extreme
    assign rssi_x    = {{2{rssi_half_db[RSSI_HALF_DB_WIDTH-1]}}, rssi_half_db};
    assign idle_th   = {{2{rssi_th[RSSI_HALF_DB_WIDTH-1]}}, rssi_th}
                     - {{(RSSI_HALF_DB_WIDTH+2-HYST_WIDTH){1'b0}}, rssi_hyst};
    assign above     = rssi_half_db >= rssi_th;
    assign below     = rssi_x < idle_th;
    assign dcnt_inc  = dcnt + 1'b1;
    assign enter_eff = (enter_cnt_th == '0) ? DEBOUNCE_WIDTH'(1) : enter_cnt_th;
    assign exit_eff  = (exit_cnt_th == '0) ? DEBOUNCE_WIDTH'(1) : exit_cnt_th;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        if (rssi_half_db_valid) begin
            case (state)
                IDLE: if (above) begin
                    state_nx = (enter_eff == DEBOUNCE_WIDTH'(1)) ? BUSY : ENTER;
                    dcnt_nx  = (enter_eff == DEBOUNCE_WIDTH'(1)) ? '0 : DEBOUNCE_WIDTH'(1);
                end
                ENTER: begin
                    state_nx = !above ? IDLE : (dcnt_inc >= enter_eff) ? BUSY : ENTER;
                    dcnt_nx  = (!above || dcnt_inc >= enter_eff) ? '0 : dcnt_inc;
                end
                BUSY: if (below) begin
                    state_nx = (exit_eff == DEBOUNCE_WIDTH'(1)) ? IDLE : EXIT;
                    dcnt_nx  = (exit_eff == DEBOUNCE_WIDTH'(1)) ? '0 : DEBOUNCE_WIDTH'(1);
                end
                EXIT: begin
                    state_nx = !below ? BUSY : (dcnt_inc >= exit_eff) ? IDLE : EXIT;
                    dcnt_nx  = (!below || dcnt_inc >= exit_eff) ? '0 : dcnt_inc;
                end
                default: begin
                    state_nx = IDLE;
                    dcnt_nx  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_nx = (state_nx == BUSY) || (state_nx == EXIT) || force_busy;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_busy      <= 1'b0;
            ch_busy_rise <= 1'b0;
            ch_busy_fall <= 1'b0;
        end else begin
            ch_busy      <= busy_nx;
            ch_busy_rise <= busy_nx & ~ch_busy;
            ch_busy_fall <= ~busy_nx & ch_busy;
        end
    end

    // clear takes priority over a coincident sample
    always_ff @(posedge clk) begin
        if (!rstn || stat_clear) begin
            busy_sample_cnt  <= '0;
            total_sample_cnt <= '0;
        end else if (rssi_half_db_valid) begin
            total_sample_cnt <= total_sample_cnt + STAT_CNT_WIDTH'(total_sample_cnt != '1);
            busy_sample_cnt  <= busy_sample_cnt + STAT_CNT_WIDTH'(busy_nx && busy_sample_cnt != '1);
        end
    end
endmodule

// File: tb/tb_cca_energy_detect.sv
// tb_cca_energy_detect: directed vectors for the CCA energy detector.
module tb_cca_energy_detect;
    localparam int SW = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic signed [10:0] rssi_half_db = '0;
    logic rssi_half_db_valid = 1'b0;
    logic signed [10:0] rssi_th = -11'sd100;
    logic [4:0] rssi_hyst = 5'd6;
    logic [7:0] enter_cnt_th = 8'd3;
    logic [7:0] exit_cnt_th = 8'd2;
    logic force_busy = 1'b0;
    logic stat_clear = 1'b0;
    logic ch_busy, ch_busy_rise, ch_busy_fall;
    logic [SW-1:0] busy_sample_cnt, total_sample_cnt;
    int n_chk = 0;
    int n_pass = 0;

    cca_energy_detect #(.STAT_CNT_WIDTH(SW)) dut (
        .clk(clk), .rstn(rstn), .rssi_half_db(rssi_half_db),
        .rssi_half_db_valid(rssi_half_db_valid), .rssi_th(rssi_th), .rssi_hyst(rssi_hyst),
        .enter_cnt_th(enter_cnt_th), .exit_cnt_th(exit_cnt_th), .force_busy(force_busy),
        .stat_clear(stat_clear), .ch_busy(ch_busy), .ch_busy_rise(ch_busy_rise),
        .ch_busy_fall(ch_busy_fall), .busy_sample_cnt(busy_sample_cnt),
        .total_sample_cnt(total_sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // three idle cycles, then one valid sample; outputs reflect it on return
    task automatic samp(input logic signed [10:0] v);
        repeat (3) tick();
        rssi_half_db = v;
        rssi_half_db_valid = 1'b1;
        tick();
        rssi_half_db_valid = 1'b0;
    endtask

    task automatic flags(input string tag, input logic b, input logic r, input logic f);
        chk({tag, "_busy"}, ch_busy, b);
        chk({tag, "_rise"}, ch_busy_rise, r);
        chk({tag, "_fall"}, ch_busy_fall, f);
    endtask

    task automatic cnts(input string tag, input int b, input int t);
        chk({tag, "_bcnt"}, busy_sample_cnt, b);
        chk({tag, "_tcnt"}, total_sample_cnt, t);
    endtask

    task automatic clear();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        flags("rst", 0, 0, 0);
        cnts("rst", 0, 0);
        rstn = 1'b1;
        tick();
        flags("rst_post", 0, 0, 0);

        samp(-11'sd90); chk("enter1", ch_busy, 0);
        samp(-11'sd90); chk("enter2", ch_busy, 0);
        samp(-11'sd90); flags("enter3", 1, 1, 0);
        cnts("enter", 1, 3);
        tick(); flags("enter_hold", 1, 0, 0);

        samp(-11'sd104); chk("band1", ch_busy, 1);
        samp(-11'sd104); chk("band2", ch_busy, 1);
        samp(-11'sd107); flags("exit1", 1, 0, 0);
        samp(-11'sd107); flags("exit2", 0, 0, 1);
        tick(); flags("exit_hold", 0, 0, 0);
        cnts("exit", 4, 7);

        clear(); cnts("clr", 0, 0);
        samp(-11'sd90); samp(-11'sd90); samp(-11'sd110);
        samp(-11'sd90); samp(-11'sd90);
        chk("intr5", ch_busy, 0);
        samp(-11'sd90); flags("intr6", 1, 1, 0);
        samp(-11'sd120); samp(-11'sd120);
        flags("intr_exit", 0, 0, 1);
        cnts("intr", 2, 8);

        enter_cnt_th = 8'd0; exit_cnt_th = 8'd0;
        samp(-11'sd100); flags("edge_eq", 1, 1, 0);
        samp(-11'sd106); chk("edge_band", ch_busy, 1);
        samp(-11'sd107); flags("edge_below", 0, 0, 1);
        rssi_th = -11'sd1024; rssi_hyst = 5'd31;
        samp(-11'sd1024); chk("min_above", ch_busy, 1);
        samp(-11'sd1024); chk("min_nowrap", ch_busy, 1);
        rssi_th = 11'sd1023; rssi_hyst = 5'd0;
        samp(-11'sd1024); chk("max_below", ch_busy, 0);
        samp(11'sd1023); chk("max_above", ch_busy, 1);
        samp(11'sd1022); chk("max_exit", ch_busy, 0);

        rssi_th = -11'sd100; rssi_hyst = 5'd6; enter_cnt_th = 8'd3; exit_cnt_th = 8'd2;
        clear();
        force_busy = 1'b1;
        tick(); flags("frc1", 1, 1, 0);
        tick(); flags("frc2", 1, 0, 0);
        rssi_half_db = -11'sd120; rssi_half_db_valid = 1'b1;
        tick(); rssi_half_db_valid = 1'b0;
        chk("frc3", ch_busy, 1);
        tick(); tick(); chk("frc5", ch_busy, 1);
        force_busy = 1'b0;
        tick(); flags("frc_off", 0, 0, 1);
        tick(); flags("frc_off2", 0, 0, 0);
        cnts("frc", 1, 1);
        samp(-11'sd90); samp(-11'sd90); chk("frc_idle", ch_busy, 0);
        samp(-11'sd90); chk("frc_enter", ch_busy, 1);
        cnts("frc_after", 2, 4);

        clear();
        for (int i = 0; i < 16; i++) samp(-11'sd90);
        cnts("sat16", 15, 15);
        samp(-11'sd90);
        cnts("sat17", 15, 15);

        stat_clear = 1'b1; rssi_half_db = -11'sd120; rssi_half_db_valid = 1'b1;
        tick();
        stat_clear = 1'b0; rssi_half_db_valid = 1'b0;
        cnts("clr_valid", 0, 0);
        chk("clr_fsm", ch_busy, 1);

        rstn = 1'b0;
        tick(); flags("rst_exit", 0, 0, 0);
        cnts("rst_exit", 0, 0);
        rstn = 1'b1;
        tick(); flags("rst_exit_post", 0, 0, 0);
        samp(-11'sd90); chk("rst_state_idle", ch_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
